// File: rtl/i2s_nch_mixer.sv
// i2s_nch_mixer
//   Multi-channel I2S receiver and stereo mixer. N_CH serial inputs share one
//   sck/ws pair. Each channel's left/right words are captured, gated by ch_en,
//   attenuated by an arithmetic right shift, and summed with saturation. The
//   mixed stereo stream is re-serialised on sd_out one frame behind the input.
//
// Ports
//   sck         : I2S bit clock. Inputs are sampled on the rising edge and
//                 sd_out is updated on the falling edge.
//   reset       : asynchronous active-low reset
//   ws          : word select (0 = left, 1 = right)
//   sd_in       : serial data, bit k = channel k
//   ch_en       : per-channel mix enable
//   gain        : per-channel right shift, gain[2k+1:2k] for channel k
//   sd_out      : mixed serial output, MSB first
//   wsp         : one-cycle word-boundary pulse
//   clip        : word currently being shifted out was saturated
//   frame_valid : a full left+right frame has been captured since reset
module i2s_nch_mixer #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned N_CH  = 4
) (
  input  logic              sck,
  input  logic              reset,
  input  logic              ws,
  input  logic [N_CH-1:0]   sd_in,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [2*N_CH-1:0] gain,
  output logic              sd_out,
  output logic              wsp,
  output logic              clip,
  output logic              frame_valid
);

  localparam int unsigned SUMW = WIDTH + $clog2(N_CH) + 1;
  // MSB of bit_idx acts as the "index went negative" flag.
  localparam int unsigned IDXW = $clog2(WIDTH) + 1;

  typedef logic [N_CH-1:0][WIDTH-1:0] word_arr_t;

  logic            ws_d1;
  logic            ws_d2;
  logic            got_left;
  logic [IDXW-1:0] bit_idx;
  word_arr_t       shadow;
  word_arr_t       left_hold;
  word_arr_t       right_hold;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] mix_left;
  logic [WIDTH-1:0] mix_right;
  logic            sat_left;
  logic            sat_right;

  assign wsp    = ws_d1 ^ ws_d2;
  assign sd_out = shift_reg[WIDTH-1];

  // Returns {saturated, result}.
  function automatic logic [WIDTH:0] mix(
    input word_arr_t         hold,
    input logic [N_CH-1:0]   en,
    input logic [2*N_CH-1:0] g
  );
    logic signed [SUMW-1:0] acc;
    logic signed [SUMW-1:0] term;
    acc = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      term = {{(SUMW-WIDTH){hold[k][WIDTH-1]}}, hold[k]};
      term = term >>> g[2*k +: 2];
      if (en[k]) acc = acc + term;
    end
    // Fits in WIDTH bits only if every bit from WIDTH-1 upward matches the sign.
    if (acc[SUMW-1:WIDTH-1] == {(SUMW-WIDTH+1){acc[SUMW-1]}})
      return {1'b0, acc[WIDTH-1:0]};
    else if (acc[SUMW-1])
      return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    {sat_left, mix_left}   = mix(left_hold, ch_en, gain);
    {sat_right, mix_right} = mix(right_hold, ch_en, gain);
  end

  // Capture and transfer. On the word boundary the completed shadow word is
  // moved to the hold of the slot that just ended, and the new MSB is taken.
  always_ff @(posedge sck or negedge reset) begin
    if (!reset) begin
      ws_d1       <= 1'b0;
      ws_d2       <= 1'b0;
      bit_idx     <= '0;
      shadow      <= '0;
      left_hold   <= '0;
      right_hold  <= '0;
      got_left    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      ws_d1 <= ws;
      ws_d2 <= ws_d1;
      if (wsp) begin
        if (ws_d1) begin
          left_hold <= shadow;
          got_left  <= 1'b1;
        end else begin
          right_hold <= shadow;
          if (got_left) frame_valid <= 1'b1;
        end
        for (int unsigned k = 0; k < N_CH; k++)
          shadow[k] <= {sd_in[k], {(WIDTH-1){1'b0}}};
        bit_idx <= IDXW'(WIDTH - 2);
      end else if (!bit_idx[IDXW-1]) begin
        for (int unsigned k = 0; k < N_CH; k++)
          shadow[k][bit_idx[IDXW-2:0]] <= sd_in[k];
        bit_idx <= bit_idx - IDXW'(1);
      end
    end
  end

  // Output serialiser. Loaded during the boundary cycle, before the new
  // transfer, so the hold registers still carry the previous frame's word.
  always_ff @(negedge sck or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      clip      <= 1'b0;
    end else if (wsp) begin
      if (ws_d1) begin
        shift_reg <= mix_right;
        clip      <= sat_right;
      end else begin
        shift_reg <= mix_left;
        clip      <= sat_left;
      end
    end else begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
    end
  end

endmodule
